modulate: RTL
=============

MODULATE -- requirements
Module: modulate

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 8, giving the number of data bits per word.
REQ-002 The block SHALL have the parameter T_ZERO, default 4, giving the high-pulse length in clk cycles for a 0 bit.
REQ-003 The block SHALL have the parameter T_ONE, default 12, giving the high-pulse length in clk cycles for a 1 bit.
REQ-004 The block SHALL have the parameter T_GAP, default 4, giving the low-gap length in clk cycles after every pulse.
REQ-005 The block SHALL have the port clk, input, width 1: the single system clock; all logic is on the rising edge.
REQ-006 The block SHALL have the port reset, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have the port in_valid, input, width 1: the upstream word is valid.
REQ-008 The block SHALL have the port in_word, input, width DATA_W: the word to transmit.
REQ-009 The block SHALL have the port in_ready, output, width 1: the block accepts a word this cycle.
REQ-010 The block SHALL have the port out_data, output, width 1: the registered pulse-width-modulated line that feeds the downstream demodulator.
REQ-011 The block SHALL have the port busy, output, width 1: a frame is in progress.
REQ-012 The block SHALL have the port done, output, width 1: a one-cycle strobe at the end of a frame.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, HIGH and GAP.
REQ-014 In IDLE, in_ready SHALL be 1; in HIGH and GAP, in_ready SHALL be 0.
REQ-015 A word SHALL be accepted on the rising clk edge where in_valid=1 and in_ready=1; it is latched into a shift register and the state moves to HIGH.
REQ-016 The block SHALL ignore in_valid and in_word while busy; nothing is buffered.
REQ-017 Bits SHALL be sent MSB first.
REQ-018 out_data SHALL be 1 in HIGH for exactly T_ZERO cycles for a 0 bit and exactly T_ONE cycles for a 1 bit, and 0 in GAP for exactly T_GAP cycles.
REQ-019 out_data SHALL rise in the first cycle after the accepting edge (latency 1 cycle).
REQ-020 At the end of GAP, the state SHALL move to HIGH for the next bit if bits remain, otherwise to IDLE.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 done SHALL be 1 for exactly the one cycle in which the state first returns to IDLE after the final gap.
REQ-023 The duration counter SHALL be 5 bits wide and the bit counter SHALL be ceil(log2(DATA_W+2)) bits wide.
REQ-024 Legal parameter values SHALL satisfy 1<=T_ZERO<=7, 8<=T_ONE<=31 and 2<=T_GAP<=31, so the downstream decision threshold (at most 7 high cycles decodes as 0, 8 or more decodes as 1) is met; other values are unsupported.
REQ-025 Because acceptance is possible only in IDLE, two back-to-back words SHALL have at least one cycle with out_data=0 beyond T_GAP, namely the IDLE cycle.

Reset
REQ-026 While reset=0, the block SHALL force out_data=0, in_ready=0, busy=0 and done=0, clear the state to IDLE and clear all counters and the shift register, asynchronously.
REQ-027 A reset asserted mid-frame SHALL drop out_data to 0 immediately and discard the partial word, with no done strobe.
REQ-028 On the first clk edge after reset deasserts, in_ready SHALL be 1.

Configuration
REQ-029 When the macro MODULATE_PARITY_EN is defined, the block SHALL append one even-parity bit (the XOR of all DATA_W data bits) after the LSB, encoded like a data bit, giving DATA_W+1 pulses per frame.
REQ-030 When MODULATE_PARITY_EN is undefined, the block SHALL send exactly DATA_W pulses and contain no parity logic.

Verification
REQ-031 Default parameters, in_word=8'hA5 accepted at cycle 0 -> out_data high runs of 12,4,12,4,4,12,4,12 cycles, each followed by a 4-cycle low gap; done at cycle 97; frame is 96 cycles.
REQ-032 in_word=8'h00 -> 8 pulses of 4 cycles each; busy=1 for 64 cycles; an attached downstream demodulator recovers 8 zeros.
REQ-033 With MODULATE_PARITY_EN, in_word=8'h01 -> 9 pulses, the last one 12 cycles long (parity 1); in_word=8'hA5 -> last pulse 4 cycles long (parity 0).
REQ-034 in_valid held at 1 with a second word 8'h3C during a frame -> the second word is not accepted until done, then in_ready=1 for one cycle in IDLE, and the second frame starts one cycle later.
REQ-035 reset driven to 0 in the middle of the third bit's HIGH state -> out_data=0 in the same cycle, no done, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/modulate_if.sv
// ============================================================================
// modulate_if : word handshake and pulse-line status bundle for modulate
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface modulate_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_word;
   logic              in_ready;
   logic              out_data;
   logic              busy;
   logic              done;

   modport master (
      output in_valid, in_word,
      input  in_ready, out_data, busy, done
   );

   modport slave (
      input  in_valid, in_word,
      output in_ready, out_data, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/modulate.sv
// ============================================================================
// modulate : sends a word MSB first as high pulses (T_ZERO/T_ONE) + T_GAP lows
// Optional even-parity pulse when MODULATE_PARITY_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module modulate #(
   parameter int DATA_W = 8,
   parameter int T_ZERO = 4,
   parameter int T_ONE  = 12,
   parameter int T_GAP  = 4
) (
   input  wire logic clk,
   input  wire logic reset,
   modulate_if.slave bus
);

`ifdef MODULATE_PARITY_EN
   localparam int NBITS = DATA_W + 1;
`else
   localparam int NBITS = DATA_W;
`endif
   localparam int CW = $clog2(DATA_W + 2);

   // Durations are loaded as length-1 and counted down to zero
   localparam logic [4:0]    LEN_ZERO = 5'(T_ZERO - 1);
   localparam logic [4:0]    LEN_ONE  = 5'(T_ONE - 1);
   localparam logic [4:0]    LEN_GAP  = 5'(T_GAP - 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(NBITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [4:0]       dur_cnt;
   logic [CW-1:0]    bit_cnt;
   logic [NBITS-1:0] shreg;
   logic             pulse_line;
   logic             accept_rdy;
   logic             frame_busy;
   logic             frame_done;
   logic [NBITS-1:0] load_word;

`ifdef MODULATE_PARITY_EN
   assign load_word = {bus.in_word, ^bus.in_word};
`else
   assign load_word = bus.in_word;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         dur_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         pulse_line <= 1'b0;
         accept_rdy <= 1'b0;
         frame_busy <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid && accept_rdy) begin
                  shreg      <= load_word;
                  dur_cnt    <= bus.in_word[DATA_W-1] ? LEN_ONE : LEN_ZERO;
                  bit_cnt    <= '0;
                  state      <= HIGH;
                  pulse_line <= 1'b1;
                  accept_rdy <= 1'b0;
                  frame_busy <= 1'b1;
               end else begin
                  accept_rdy <= 1'b1;
               end
            end
            HIGH: begin
               if (dur_cnt == 5'd0) begin
                  state      <= GAP;
                  dur_cnt    <= LEN_GAP;
                  pulse_line <= 1'b0;
                  shreg      <= {shreg[NBITS-2:0], 1'b0};
                  bit_cnt    <= bit_cnt + CW'(1);
               end else begin
                  dur_cnt <= dur_cnt - 5'd1;
               end
            end
            GAP: begin
               if (dur_cnt != 5'd0) begin
                  dur_cnt <= dur_cnt - 5'd1;
               end else if (bit_cnt == LAST_BIT) begin
                  state      <= IDLE;
                  frame_busy <= 1'b0;
                  frame_done <= 1'b1;
                  accept_rdy <= 1'b1;
               end else begin
                  // shreg was already shifted, so its MSB is the next bit
                  state      <= HIGH;
                  pulse_line <= 1'b1;
                  dur_cnt    <= shreg[NBITS-1] ? LEN_ONE : LEN_ZERO;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_data = pulse_line;
   assign bus.in_ready = accept_rdy;
   assign bus.busy     = frame_busy;
   assign bus.done     = frame_done;

endmodule

`default_nettype wire
